// File: rtl/tnn_feed_pkg.sv
// Shared types and constants for the ternary-classifier feature feeder.
package tnn_feed_pkg;

  localparam int unsigned NUM_FEAT = 32'd5;

  typedef logic [1:0] feat_code_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DRAIN   = 2'd2
  } feed_state_e;

endpackage

// File: rtl/tnn_feature_feeder_if.sv
// Raw-sample input stream, quantised-vector output stream and frame status.
interface tnn_feature_feeder_if #(
  parameter int unsigned RAW_W = 32'd8
);
  import tnn_feed_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [RAW_W-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  feat_code_t       out_a;
  feat_code_t       out_b;
  feat_code_t       out_c;
  feat_code_t       out_d;
  feat_code_t       out_e;
  logic             frame_err;
  logic [15:0]      frame_cnt;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, out_a, out_b, out_c, out_d, out_e,
           frame_err, frame_cnt
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, out_a, out_b, out_c, out_d, out_e,
           frame_err, frame_cnt
  );

endinterface

// File: rtl/tnn_quant2.sv
// Combinational 2-bit threshold quantiser: maps an unsigned sample onto 0..3.
module tnn_quant2
  import tnn_feed_pkg::*;
#(
  parameter int unsigned RAW_W = 32'd8,
  parameter int unsigned THR0  = 32'd64,
  parameter int unsigned THR1  = 32'd128,
  parameter int unsigned THR2  = 32'd192
) (
  input  logic [RAW_W-1:0] x_i,
  output feat_code_t       code_o
);

  localparam logic [RAW_W-1:0] T0 = RAW_W'(THR0);
  localparam logic [RAW_W-1:0] T1 = RAW_W'(THR1);
  localparam logic [RAW_W-1:0] T2 = RAW_W'(THR2);

  // Highest threshold reached wins.
  always_comb begin
    code_o = 2'd0;
    if (x_i >= T2) begin
      code_o = 2'd3;
    end else if (x_i >= T1) begin
      code_o = 2'd2;
    end else if (x_i >= T0) begin
      code_o = 2'd1;
    end else begin
      code_o = 2'd0;
    end
  end

endmodule

// File: rtl/tnn_feature_feeder.sv
// Collects five raw samples per frame, quantises them and presents one
// 2-bit feature vector per well-formed frame to the classifier.
module tnn_feature_feeder
  import tnn_feed_pkg::*;
#(
  parameter int unsigned RAW_W    = 32'd8,
  parameter int unsigned NUM_FEAT = tnn_feed_pkg::NUM_FEAT,
  parameter int unsigned THR0     = 32'd64,
  parameter int unsigned THR1     = 32'd128,
  parameter int unsigned THR2     = 32'd192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tnn_feature_feeder_if.slave   bus
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_FEAT - 32'd1);

  feed_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  feat_code_t  slots_q [NUM_FEAT];
  feat_code_t  slots_d [NUM_FEAT];
  logic        m_valid_q, m_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  feat_code_t  code_s;
  logic        s_ready_s;
  logic        s_hs_s;

  tnn_quant2 #(
    .RAW_W (RAW_W),
    .THR0  (THR0),
    .THR1  (THR1),
    .THR2  (THR2)
  ) u_quant (
    .x_i    (bus.s_data),
    .code_o (code_s)
  );

  // Held low through reset so nothing is accepted before the FSM is live.
  assign s_ready_s = rst_n & (state_q != ST_PRESENT);
  assign s_hs_s    = bus.s_valid & s_ready_s;

  // Next-state, slot write and status update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slots_d     = slots_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (s_hs_s) begin
          slots_d[idx_q] = code_s;
          if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
            if (bus.s_last) begin
              state_d   = ST_PRESENT;
              m_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_DRAIN;
            end
          end else if (bus.s_last) begin
            frame_err_d = 1'b1;
            idx_d       = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PRESENT: begin
        if (bus.m_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          m_valid_d   = 1'b0;
          state_d     = ST_COLLECT;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_DRAIN: begin
        if (s_hs_s && bus.s_last) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d   = ST_COLLECT;
        idx_d     = 3'd0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= 3'd0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      for (int i = 0; i < int'(NUM_FEAT); i++) begin
        slots_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      slots_q     <= slots_d;
    end
  end

  assign bus.s_ready   = s_ready_s;
  assign bus.m_valid   = m_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.out_a     = slots_q[0];
  assign bus.out_b     = slots_q[1];
  assign bus.out_c     = slots_q[2];
  assign bus.out_d     = slots_q[3];
  assign bus.out_e     = slots_q[4];

endmodule

// File: tb/tb_tnn_feature_feeder.sv
// Directed bench for tnn_feature_feeder with hand-computed expected vectors.
module tb_tnn_feature_feeder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tnn_feature_feeder_if #(.RAW_W(32'd8)) bus ();

  tnn_feature_feeder #(
    .RAW_W    (32'd8),
    .NUM_FEAT (32'd5),
    .THR0     (32'd64),
    .THR1     (32'd128),
    .THR2     (32'd192)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, 1'b0);
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready got=%b want=0", bus.s_ready);
    end
    checks++;
    if ({bus.m_valid, bus.frame_err, bus.frame_cnt, outs()} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0",
                         {bus.m_valid, bus.frame_err, bus.frame_cnt, outs()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_s_ready got=%b want=1", bus.s_ready);
    end
  endtask

  task automatic test_basic_frame();
    bus.m_ready = 1'b1;
    send4(8'd10, 8'd70, 8'd130, 8'd200);
    send_beat(8'd255, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1 || outs() !== 10'b00_01_10_11_11) begin
      errors++; $display("FAIL basic_vector got=%b/%b want=1/0001101111", bus.m_valid, outs());
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL basic_present_s_ready got=%b want=0", bus.s_ready);
    end
    step();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.frame_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_after got=%b/%0d want=0/1", bus.m_valid, bus.frame_cnt);
    end
  endtask

  task automatic test_boundaries();
    bus.m_ready = 1'b1;
    send4(8'd63, 8'd64, 8'd127, 8'd128);
    send_beat(8'd192, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1 || outs() !== 10'b00_01_01_10_11) begin
      errors++; $display("FAIL boundary_vector got=%b/%b want=1/0001011011", bus.m_valid, outs());
    end
    step();
    checks++;
    if (bus.frame_cnt !== 16'd2) begin
      errors++; $display("FAIL boundary_cnt got=%0d want=2", bus.frame_cnt);
    end
  endtask

  task automatic test_short_frame();
    bus.m_ready = 1'b1;
    send_beat(8'd200, 1'b0);
    send_beat(8'd200, 1'b0);
    send_beat(8'd200, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL short_err got=%b/%b want=1/0", bus.frame_err, bus.m_valid);
    end
    step();
    checks++;
    if (bus.frame_err !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL short_pulse_width got=%b/%b want=0/0", bus.frame_err, bus.m_valid);
    end
    send4(8'd0, 8'd255, 8'd100, 8'd150);
    send_beat(8'd64, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1 || outs() !== 10'b00_11_01_10_01) begin
      errors++; $display("FAIL short_next_vector got=%b/%b want=1/0011011001", bus.m_valid, outs());
    end
    step();
    checks++;
    if (bus.frame_cnt !== 16'd3) begin
      errors++; $display("FAIL short_cnt got=%0d want=3", bus.frame_cnt);
    end
  endtask

  task automatic test_long_frame();
    bus.m_ready = 1'b1;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    send_beat(8'd5, 1'b0);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL long_err got=%b/%b/%b want=1/1/0",
                         bus.frame_err, bus.s_ready, bus.m_valid);
    end
    send_beat(8'd6, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL long_drain got=%b/%b want=0/0", bus.frame_err, bus.m_valid);
    end
    send4(8'd200, 8'd130, 8'd70, 8'd10);
    send_beat(8'd128, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1 || outs() !== 10'b11_10_01_00_10) begin
      errors++; $display("FAIL long_next_vector got=%b/%b want=1/1110010010", bus.m_valid, outs());
    end
    step();
    checks++;
    if (bus.frame_cnt !== 16'd4) begin
      errors++; $display("FAIL long_cnt got=%0d want=4", bus.frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    bus.m_ready = 1'b0;
    send4(8'd255, 8'd0, 8'd191, 8'd127);
    send_beat(8'd63, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd250;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 ||
          outs() !== 10'b11_00_10_01_00 || bus.frame_cnt !== 16'd4) begin
        bad++;
      end
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad);
    end
    bus.m_ready = 1'b1;
    step();
    checks++;
    if (bus.frame_cnt !== 16'd5 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got=%0d/%b want=5/0", bus.frame_cnt, bus.m_valid);
    end
    step();
    checks++;
    if (bus.frame_cnt !== 16'd5 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL stall_single_inc got=%0d/%b want=5/0", bus.frame_cnt, bus.m_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.m_ready = 1'b1;
    send_beat(8'd255, 1'b0);
    send_beat(8'd255, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.m_valid, bus.frame_err, bus.frame_cnt, outs()} !== 29'd0) begin
      errors++; $display("FAIL midreset_outputs got=%h want=0",
                         {bus.s_ready, bus.m_valid, bus.frame_err, bus.frame_cnt, outs()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send4(8'd10, 8'd70, 8'd130, 8'd200);
    send_beat(8'd255, 1'b1);
    checks++;
    if (bus.m_valid !== 1'b1 || outs() !== 10'b00_01_10_11_11) begin
      errors++; $display("FAIL midreset_vector got=%b/%b want=1/0001101111", bus.m_valid, outs());
    end
    step();
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++; $display("FAIL midreset_cnt got=%0d want=1", bus.frame_cnt);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_boundaries();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
